// File: rtl/bin2bcd_ctrl.sv
// bin2bcd_ctrl: sequential double-dabble binary-to-BCD converter.
// One shift-add-3 iteration per clock, valid/ready handshakes on both sides,
// one conversion in flight at a time.
// Optional macro BIN2BCD_CTRL_CNT_EN adds the 16-bit conv_cnt output that
// counts completed output handshakes.
module bin2bcd_ctrl #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BIN2BCD_CTRL_CNT_EN
    output logic [15:0]           conv_cnt,
`endif
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SH_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SH_W-1:0]    r_sh;
    logic [SH_W-1:0]    w_sh_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [BCD_W-1:0]   w_adj;
    logic [SH_W-1:0]    w_shifted;

    // Add-3 correction on every pre-shift digit that is 5 or more, then shift.
    always_comb begin
        w_adj = r_sh[SH_W-1 -: BCD_W];
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (w_adj[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = w_adj[4*d +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adj, r_sh[BIN_W-1:0]} << 1;
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_bcd_nxt   = r_bcd;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_sh_nxt    = {BCD_W'(0), bin_in};
                    w_cnt_nxt   = CNT_W'(0);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sh_nxt  = w_shifted;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_bcd_nxt   = w_shifted[SH_W-1 -: BCD_W];
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh        <= w_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bcd       <= w_bcd_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_SHIFT);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bcd_out   = r_bcd;

`ifdef BIN2BCD_CTRL_CNT_EN
    logic [15:0] r_conv_cnt;

    // Count completed output handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conv_cnt <= '0;
        end else if (r_state == S_DONE && out_ready) begin
            r_conv_cnt <= r_conv_cnt + 16'd1;
        end
    end

    assign conv_cnt = r_conv_cnt;
`endif

endmodule

// File: doc/bin2bcd_ctrl.md
# bin2bcd_ctrl

Sequential binary-to-BCD converter with valid/ready handshakes on both sides. It iterates the double-dabble shift-add-3 algorithm one bit per clock. It replaces the combinational `bin2bcd` wherever conversion results feed registered logic, such as display drivers or UART formatters, and area matters more than latency. One conversion is in flight at a time.

## Interface
- `BIN_W`, 8: binary input width in bits; must be at least 2.
- `DIGITS`, 3: number of BCD digits produced. Must satisfy `10**DIGITS > 2**BIN_W - 1`.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: `bin_in` carries a value to convert.
- `in_ready`  out  1: controller can accept a new value.
- `bin_in`  in  BIN_W: unsigned binary operand.
- `out_valid`  out  1: `bcd_out` holds a completed result.
- `out_ready`  in  1: consumer accepts the result.
- `bcd_out`  out  4*DIGITS: packed BCD; digit 0 is the units digit in bits [3:0].
- `busy`  out  1: a conversion is in progress (SHIFT state).

## Operation
- FSM states:
  - IDLE: `in_ready`=1. An input handshake (`in_valid && in_ready`) loads the shift register with {zeros, `bin_in`}, clears the iteration counter and moves to SHIFT.
  - SHIFT: one iteration per cycle. Each BCD digit ≥5 gets +3 added, then the whole {bcd, bin} register shifts left by 1. After iteration BIN_W: `bcd_out` is loaded and the FSM moves to DONE.
  - DONE: `out_valid`=1. An output handshake (`out_valid && out_ready`) moves the FSM to IDLE.
- All outputs are registered:
  - `in_ready` = (state==IDLE).
  - `busy` = (state==SHIFT).
  - `out_valid` = (state==DONE).
- `bcd_out` changes only on the SHIFT→DONE transition. It keeps its value through IDLE until the next result.
- `bin_in` is sampled only on the input handshake cycle; later changes have no effect.
- `in_valid` is ignored outside IDLE. The input side is not buffered: a producer must hold `in_valid` until it sees `in_ready`.
- Digit correction compares the pre-shift digit against 5 using a 4-bit add. Digits never exceed 9 after a shift.
- High digits unreachable for the given BIN_W stay 0. For example, with the defaults `bcd_out[11:10]` is always 0.

## Timing
- Reset (`rst_n` low at a rising edge):
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `bcd_out`=0.
  - The iteration counter and shift register are cleared.
- Latency: the input handshake occurs at edge E0. `out_valid` rises after edge E0+BIN_W, i.e. 8 cycles with the defaults.
- `out_valid` and `bcd_out` hold stable until the output handshake edge. `out_valid` falls and `in_ready` rises after that edge.
- Throughput, with `in_valid` and `out_ready` held at 1: one result every BIN_W+2 cycles, i.e. 10 with the defaults.
- Backpressure: with `out_ready`=0 the FSM stays in DONE indefinitely and `in_ready` stays 0.
- Reset mid-conversion (SHIFT or DONE): aborts immediately at that edge. No partial result appears; `bcd_out` reads 0.
- Iteration counter width: clog2(BIN_W+1). It does not wrap within a conversion.

## Configuration
- Macro `BIN2BCD_CTRL_CNT_EN`:
  - Defined: adds output `conv_cnt`  out  16, reset value 0. It increments by 1 on every output handshake and wraps 16'hFFFF→0.
  - Undefined: the port and counter do not exist. Conversion behaviour is identical in both builds.

## Test plan
- Reset, then `bin_in`=0 with one `in_valid` pulse, `out_ready`=1 → `out_valid` rises after edge E0+8 with `bcd_out`=12'h000; `in_ready`=1 one cycle later.
- `bin_in`=255, then 99, then 100 → `bcd_out`=12'h255, 12'h099 and 12'h100 respectively; `busy` high for exactly 8 cycles each.
- Back-to-back: `in_valid`=1 and `out_ready`=1 held, 20 `$random` inputs → each result equals the decimal value of its input. Results are spaced exactly 10 cycles apart.
- Backpressure: `out_ready`=0 for 15 cycles after `out_valid` rises → `bcd_out` stable and `in_ready`=0 throughout. `bin_in` changes are ignored. Result is accepted on the first `out_ready`=1 edge.
- Reset asserted at iteration 4 of converting 200 → next cycle state is IDLE with `out_valid`=0 and `bcd_out`=0. A new conversion of 37 then yields 12'h037.
- With `BIN2BCD_CTRL_CNT_EN` defined: 3 completed handshakes → `conv_cnt`=3. A force to 16'hFFFF followed by one handshake → `conv_cnt`=0.
